// File: rtl/display_scanner_pkg.sv
// Shared definitions for the 4-digit multiplexed hex display scanner.
//   - scan_state_e : IDLE/SCAN state encoding
//   - NUM_DIGITS   : number of multiplexed digits
//   - DIV_DEFAULT  : default refresh period (clock cycles per digit)
//   - AN_OFF       : active-low digit enable pattern with every digit dark
//   - helper functions for nibble selection and leading-zero detection
package display_scanner_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  localparam int          NUM_DIGITS  = 4;
  localparam int          DIGIT_W     = $clog2(NUM_DIGITS);
  localparam int unsigned DIV_DEFAULT = 50000;
  localparam logic [3:0]  AN_OFF      = 4'b1111;

  // Nibble shown on digit d (digit 0 is the least significant nibble).
  function automatic logic [3:0] digit_nibble(input logic [15:0] value,
                                              input logic [DIGIT_W-1:0] d);
    return value[4*d +: 4];
  endfunction

  // True when digit d is a leading zero: d is not the units digit and every
  // nibble from d up to the most significant one is zero.
  function automatic logic is_leading_zero(input logic [15:0] value,
                                           input logic [DIGIT_W-1:0] d);
    logic all_zero;
    all_zero = 1'b1;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (k >= int'(d)) begin
        all_zero = all_zero & (value[4*k +: 4] == 4'h0);
      end
    end
    return (d != '0) && all_zero;
  endfunction

endpackage

// File: rtl/display_scanner_refresh.sv
// refresh_counter: digit refresh prescaler.
//   clk, rst_n : system clock, asynchronous active-low reset
//   en         : count enable; the count holds its value while low
//   clr        : synchronous clear to zero, wins over en
//   tick       : one-cycle pulse in the cycle where the count wraps DIV-1 -> 0
module refresh_counter
  import display_scanner_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEFAULT,
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  logic [CW-1:0] count_q, count_d;
  logic          at_top;

  always_comb begin
    at_top  = (count_q == CW'(DIV - 1));
    tick    = en && !clr && at_top;
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = at_top ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/display_scanner.sv
// display_scanner: drives a 4-digit common-anode hex display through an
// external hex decoder by time-multiplexing the digits.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   result[15:0]: value to show; captured into the hold register on load
//   load        : single-cycle capture strobe (also starts scanning from IDLE)
//   clear       : synchronous return to IDLE, wins over load
//   enable      : 1 = scan and drive digits, 0 = freeze position and go dark
//   blank_lz    : 1 = suppress leading-zero digits (units digit always shown)
//   q3..q0      : nibble for the decoder, q3 is the MSB
//   Read        : decoder enable (0 = all segments off)
//   an[3:0]     : active-low digit enables, an[0] = least significant digit
// All display outputs are registered and therefore lag the internal state by
// one clock; reset darkens them asynchronously.
module display_scanner
  import display_scanner_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] result,
  input  logic        load,
  input  logic        clear,
  input  logic        enable,
  input  logic        blank_lz,
  output logic        q3,
  output logic        q2,
  output logic        q1,
  output logic        q0,
  output logic        Read,
  output logic [3:0]  an
);

  scan_state_e        state_q, state_d;
  logic [15:0]        hold_q, hold_d;
  logic [DIGIT_W-1:0] digit_q, digit_d;
  logic [3:0]         an_q, an_d;
  logic [3:0]         nib_q, nib_d;
  logic               read_q, read_d;

  logic               capture;
  logic               cnt_en;
  logic               cnt_clr;
  logic               tick;

  // The prescaler only runs while actively scanning; it is held at zero in
  // IDLE so that entering SCAN always starts a full digit period.
  refresh_counter #(.DIV(DIV)) u_refresh (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (cnt_en),
    .clr  (cnt_clr),
    .tick (tick)
  );

  always_comb begin
    capture = load && !clear;
    cnt_en  = (state_q == ST_SCAN) && enable && !clear;
    cnt_clr = (state_q != ST_SCAN) || clear;

    state_d = state_q;
    hold_d  = capture ? result : hold_q;
    digit_d = digit_q;

    case (state_q)
      ST_IDLE: begin
        digit_d = '0;
        if (capture) begin
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (clear) begin
          state_d = ST_IDLE;
          digit_d = '0;
        end else if (tick) begin
          // Four digits: the 2-bit index wraps 3 -> 0 on its own.
          digit_d = digit_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        digit_d = '0;
      end
    endcase

    // Output image for the next cycle, built from the present state.
    an_d   = AN_OFF;
    nib_d  = 4'h0;
    read_d = 1'b0;
    if ((state_q == ST_SCAN) && enable) begin
      an_d   = AN_OFF ^ (4'b0001 << digit_q);
      nib_d  = digit_nibble(hold_q, digit_q);
      // A blanked digit keeps its anode active; only the decoder is disabled.
      read_d = !(blank_lz && is_leading_zero(hold_q, digit_q));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      digit_q <= '0;
      an_q    <= AN_OFF;
      nib_q   <= 4'h0;
      read_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      digit_q <= digit_d;
      an_q    <= an_d;
      nib_q   <= nib_d;
      read_q  <= read_d;
    end
  end

  assign q3   = nib_q[3];
  assign q2   = nib_q[2];
  assign q1   = nib_q[1];
  assign q0   = nib_q[0];
  assign Read = read_q;
  assign an   = an_q;

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner with DIV=4. A reference model
// tracks "enabled cycles since scanning started" and derives the digit from
// it arithmetically; every cycle the DUT outputs are compared with it, and
// directed scenarios additionally compare against hand-derived tables.
module tb_display_scanner;

  localparam int DIV = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] result;
  logic        load;
  logic        clear;
  logic        enable;
  logic        blank_lz;
  logic        q3, q2, q1, q0;
  logic        Read;
  logic [3:0]  an;
  logic [3:0]  dq;

  int n_checks = 0;
  int n_fail   = 0;

  display_scanner #(.DIV(DIV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .result  (result),
    .load    (load),
    .clear   (clear),
    .enable  (enable),
    .blank_lz(blank_lz),
    .q3      (q3),
    .q2      (q2),
    .q1      (q1),
    .q0      (q0),
    .Read    (Read),
    .an      (an)
  );

  assign dq = {q3, q2, q1, q0};

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit          m_scan  = 1'b0;
  logic [15:0] m_hold  = 16'h0;
  int          m_phase = 0;
  logic [3:0]  exp_an   = 4'hF;
  logic [3:0]  exp_q    = 4'h0;
  logic        exp_read = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int d;
    if (!rst_n) begin
      m_scan   = 1'b0;
      m_hold   = 16'h0;
      m_phase  = 0;
      exp_an   = 4'hF;
      exp_q    = 4'h0;
      exp_read = 1'b0;
    end else begin
      // What the display shows next cycle follows the pre-edge state.
      d = (m_phase / DIV) % 4;
      if (m_scan && enable) begin
        exp_an   = 4'hF ^ (4'h1 << d);
        exp_q    = 4'((m_hold >> (4 * d)) & 16'hF);
        exp_read = !(blank_lz && (d != 0) && ((m_hold >> (4 * d)) == 16'h0));
      end else begin
        exp_an   = 4'hF;
        exp_q    = 4'h0;
        exp_read = 1'b0;
      end
      if (clear) begin
        m_scan  = 1'b0;
        m_phase = 0;
      end else begin
        if (load) m_hold = result;
        if (!m_scan) begin
          if (load) begin
            m_scan  = 1'b1;
            m_phase = 0;
          end
        end else if (enable) begin
          m_phase = m_phase + 1;
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and compare outputs with the model at the falling edge.
  task automatic cycle();
    @(negedge clk);
    check("model_an",   16'(an),   16'(exp_an));
    check("model_read", 16'(Read), 16'(exp_read));
    check("model_q",    16'(dq),   16'(exp_q));
  endtask

  // ---------------- driver tasks ----------------
  // Return to IDLE, then start a fresh scan of v. Returns after the load edge;
  // the next cycle() observes digit 0.
  task automatic start_scan(input logic [15:0] v);
    clear = 1'b1;
    cycle();
    clear  = 1'b0;
    load   = 1'b1;
    result = v;
    cycle();
    load = 1'b0;
  endtask

  logic [3:0] an_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [3:0] q_tab  [4] = '{4'hF, 4'h2, 4'hA, 4'h1};
  logic       rd_tab [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    rst_n = 1'b0; result = '0; load = 1'b0; clear = 1'b0;
    enable = 1'b1; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_an",   16'(an),   16'hF);
    check("reset_read", 16'(Read), 16'h0);
    check("reset_q",    16'(dq),   16'h0);
    rst_n = 1'b1;

    // Reset only, no load: dark for 50 cycles.
    for (int i = 0; i < 50; i++) begin
      cycle();
      check("idle_an", 16'(an), 16'hF);
      check("idle_read", 16'(Read), 16'h0);
    end

    // 1A2F, no blanking: F/2/A/1 four cycles each, repeating.
    start_scan(16'h1A2F);
    for (int i = 0; i < 20; i++) begin
      cycle();
      check("seq_an",   16'(an),   16'(an_tab[(i % 16) / 4]));
      check("seq_q",    16'(dq),   16'(q_tab[(i % 16) / 4]));
      check("seq_read", 16'(Read), 16'h1);
    end

    // Leading-zero blanking.
    blank_lz = 1'b1;
    start_scan(16'h002F);
    for (int i = 0; i < 16; i++) begin
      cycle();
      check("blz_an",   16'(an),   16'(an_tab[i / 4]));
      check("blz_read", 16'(Read), 16'(rd_tab[i / 4]));
    end
    start_scan(16'h0000);
    for (int i = 0; i < 16; i++) begin
      cycle();
      check("zero_an",   16'(an),   16'(an_tab[i / 4]));
      check("zero_read", 16'(Read), (i < 4) ? 16'h1 : 16'h0);
      check("zero_q",    16'(dq),   16'h0);
    end
    blank_lz = 1'b0;

    // Enable gap after one displayed cycle of digit 2.
    start_scan(16'h1A2F);
    repeat (9) cycle();
    check("gap_pre_an", 16'(an), 16'hB);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("gap_an", 16'(an), 16'hF);
      check("gap_read", 16'(Read), 16'h0);
    end
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("resume_an", 16'(an), (i < 3) ? 16'hB : 16'h7);
    end

    // load and clear together during SCAN: clear wins, hold untouched.
    load = 1'b1; clear = 1'b1; result = 16'hBEEF;
    cycle();
    load = 1'b0; clear = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (i > 0) check("clr_an", 16'(an), 16'hF);
    end
    check("clr_hold", dut.hold_q, 16'h1A2F);
    load = 1'b1; result = 16'h0001;
    cycle();
    load = 1'b0;
    cycle();
    check("after_clr_an", 16'(an), 16'hE);
    check("after_clr_q",  16'(dq), 16'h1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      load     = ($urandom_range(0, 9) == 0);
      clear    = ($urandom_range(0, 39) == 0);
      enable   = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      result   = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      cycle();
    end
    load = 1'b0; clear = 1'b0; enable = 1'b1; blank_lz = 1'b0;

    // Asynchronous reset between edges while digit 1 is showing.
    start_scan(16'h1A2F);
    repeat (5) cycle();
    check("pre_rst_an", 16'(an), 16'hD);
    #2 rst_n = 1'b0;
    #1;
    check("async_an",   16'(an),   16'hF);
    check("async_read", 16'(Read), 16'h0);
    check("async_q",    16'(dq),   16'h0);
    #1 rst_n = 1'b1;
    check("rst_hold", dut.hold_q, 16'h0);
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("post_rst_an", 16'(an), 16'hF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
